// File: rtl/or1200_vlx_bus_arb.sv
// Data-side Wishbone arbiter between the OR1200 LSU and the VLX bit-packer.
// Define OR1200_VLX_ARB_RR_EN for round-robin grants; default is fixed LSU priority.
module or1200_vlx_bus_arb #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TMO_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_sel_i,
    input  logic [31:0] lsu_adr_i,
    input  logic [31:0] lsu_dat_i,
    output logic [31:0] lsu_dat_o,
    output logic        lsu_ack_o,
    output logic        lsu_err_o,
    input  logic        vlx_req_i,
    input  logic [31:0] vlx_adr_i,
    input  logic [7:0]  vlx_dat_i,
    input  logic        vlx_pair_i,
    output logic        vlx_ack_o,
    output logic        vlx_err_o,
    output logic        vlx_busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        LSU_XFER,
        VLX_XFER,
        VLX_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [TMO_W-1:0]  wdt_q, wdt_d;
    logic              tmo, ack_ev, err_ev, drop;
    logic              grant_lsu, grant_vlx;
`ifdef OR1200_VLX_ARB_RR_EN
    logic              rr_q, rr_d;
`endif

    // A timeout only counts when the slave is not acking in the same cycle.
    assign tmo    = (TIMEOUT_CYC != 0) && (wdt_q >= TMO_W'(TIMEOUT_CYC));
    assign ack_ev = wb_ack_i & ~wb_err_i;
    assign err_ev = wb_err_i | (tmo & ~wb_ack_i);

`ifdef OR1200_VLX_ARB_RR_EN
    // rr_q = 1 gives the VLX priority on a tie.
    assign grant_lsu = lsu_req_i & (~vlx_req_i | ~rr_q);
    assign grant_vlx = vlx_req_i & ~grant_lsu;
`else
    assign grant_lsu = lsu_req_i;
    assign grant_vlx = vlx_req_i & ~lsu_req_i;
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        wdt_d     = (&wdt_q) ? wdt_q : wdt_q + 1'b1;
        drop      = 1'b0;
        lsu_ack_o = 1'b0;
        lsu_err_o = 1'b0;
        vlx_ack_o = 1'b0;
        vlx_err_o = 1'b0;
`ifdef OR1200_VLX_ARB_RR_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                wdt_d = '0;
                if (grant_lsu) begin
                    state_d = LSU_XFER;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = lsu_we_i;
                    sel_d   = lsu_sel_i;
                    adr_d   = lsu_adr_i;
                    dat_d   = lsu_dat_i;
`ifdef OR1200_VLX_ARB_RR_EN
                    rr_d    = 1'b1;
`endif
                end else if (grant_vlx) begin
                    state_d = VLX_XFER;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = 4'b1000 >> vlx_adr_i[1:0];
                    adr_d   = vlx_adr_i;
                    dat_d   = {4{vlx_dat_i}};
`ifdef OR1200_VLX_ARB_RR_EN
                    rr_d    = 1'b0;
`endif
                end
            end
            LSU_XFER: begin
                lsu_ack_o = ack_ev;
                lsu_err_o = err_ev;
                drop      = ack_ev | err_ev;
            end
            VLX_XFER: begin
                vlx_ack_o = ack_ev;
                vlx_err_o = err_ev;
                if (err_ev) begin
                    drop = 1'b1;
                end else if (ack_ev) begin
                    if (vlx_pair_i) begin
                        state_d = VLX_HOLD;
                        stb_d   = 1'b0;
                        wdt_d   = '0;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            VLX_HOLD: begin
                // Bus stays locked; only the second VLX byte or a timeout leaves.
                vlx_err_o = tmo;
                if (tmo) begin
                    drop = 1'b1;
                end else if (vlx_req_i) begin
                    state_d = VLX_XFER;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = 4'b1000 >> vlx_adr_i[1:0];
                    adr_d   = vlx_adr_i;
                    dat_d   = {4{vlx_dat_i}};
                    wdt_d   = '0;
                end
            end
        endcase
        if (drop) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = '0;
            adr_d   = '0;
            dat_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            wdt_q   <= '0;
`ifdef OR1200_VLX_ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            wdt_q   <= wdt_d;
`ifdef OR1200_VLX_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_sel_o   = sel_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign lsu_dat_o  = wb_dat_i;
    assign vlx_busy_o = (state_q == VLX_XFER) || (state_q == VLX_HOLD);

endmodule

// File: tb/tb_or1200_vlx_bus_arb.sv
// Directed self-checking bench for or1200_vlx_bus_arb (TIMEOUT_CYC=16).
// Expected grant order follows OR1200_VLX_ARB_RR_EN when it is defined.
module tb_or1200_vlx_bus_arb;

    logic        clk, rst;
    logic        lsu_req, lsu_we;
    logic [3:0]  lsu_sel;
    logic [31:0] lsu_adr, lsu_dat, lsu_rdat;
    logic        lsu_ack, lsu_err;
    logic        vlx_req, vlx_pair;
    logic [31:0] vlx_adr;
    logic [7:0]  vlx_dat;
    logic        vlx_ack, vlx_err, vlx_busy;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    logic        wack, werr;
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  t4_vlx;

    or1200_vlx_bus_arb #(.TIMEOUT_CYC(16), .TMO_W(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_sel_i(lsu_sel),
        .lsu_adr_i(lsu_adr), .lsu_dat_i(lsu_dat), .lsu_dat_o(lsu_rdat),
        .lsu_ack_o(lsu_ack), .lsu_err_o(lsu_err),
        .vlx_req_i(vlx_req), .vlx_adr_i(vlx_adr), .vlx_dat_i(vlx_dat),
        .vlx_pair_i(vlx_pair), .vlx_ack_o(vlx_ack), .vlx_err_o(vlx_err),
        .vlx_busy_o(vlx_busy),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
        .wb_adr_o(adr), .wb_dat_o(wdat), .wb_dat_i(rdat),
        .wb_ack_i(wack), .wb_err_i(werr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        lsu_req = 0; lsu_we = 0; lsu_sel = 0; lsu_adr = 0; lsu_dat = 0;
        vlx_req = 0; vlx_pair = 0; vlx_adr = 0; vlx_dat = 0;
        rdat = 0; wack = 0; werr = 0;
`ifdef OR1200_VLX_ARB_RR_EN
        t4_vlx = 4'b0101;
`else
        t4_vlx = 4'b0000;
`endif
        nxt();
        chk("rst_cyc", {31'd0, cyc}, 0);
        chk("rst_stb", {31'd0, stb}, 0);
        chk("rst_busy", {31'd0, vlx_busy}, 0);
        chk("rst_adr", adr, 0);
        nxt();
        rst = 1'b0;

        // Reset while VLX owns the bus
        nxt();
        vlx_req = 1; vlx_adr = 32'h10; vlx_dat = 8'h3C;
        nxt();
        chk("t1_cyc_up", {31'd0, cyc}, 1);
        rst = 1'b1; wack = 1'b1;
        #1;
        chk("t1_cyc", {31'd0, cyc}, 0);
        chk("t1_stb", {31'd0, stb}, 0);
        chk("t1_we", {31'd0, we}, 0);
        chk("t1_sel", {28'd0, sel}, 0);
        chk("t1_adr", adr, 0);
        chk("t1_dat", wdat, 0);
        chk("t1_busy", {31'd0, vlx_busy}, 0);
        chk("t1_ack", {31'd0, vlx_ack}, 0);
        vlx_req = 0; wack = 0;
        nxt();
        rst = 1'b0;
        nxt();
        chk("t1_idle_cyc", {31'd0, cyc}, 0);
        chk("t1_idle_busy", {31'd0, vlx_busy}, 0);

        // Single VLX byte, two wait states
        vlx_req = 1; vlx_adr = 32'h0383C1D1; vlx_dat = 8'hA5; vlx_pair = 0;
        nxt();
        chk("t2_stb1", {31'd0, stb}, 1);
        chk("t2_sel", {28'd0, sel}, 32'h4);
        chk("t2_dat", wdat, 32'hA5A5A5A5);
        chk("t2_adr", adr, 32'h0383C1D1);
        chk("t2_we", {31'd0, we}, 1);
        chk("t2_noack1", {31'd0, vlx_ack}, 0);
        nxt();
        chk("t2_stb2", {31'd0, stb}, 1);
        chk("t2_noack2", {31'd0, vlx_ack}, 0);
        nxt();
        wack = 1;
        #1;
        chk("t2_stb3", {31'd0, stb}, 1);
        chk("t2_ack", {31'd0, vlx_ack}, 1);
        chk("t2_lsu_noack", {31'd0, lsu_ack}, 0);
        nxt();
        wack = 0; vlx_req = 0;
        chk("t2_stb_end", {31'd0, stb}, 0);
        chk("t2_cyc_end", {31'd0, cyc}, 0);

        // FF/00 pair with LSU arriving during hold
        vlx_req = 1; vlx_adr = 32'h100; vlx_dat = 8'hFF; vlx_pair = 1;
        nxt();
        chk("t3_sel_ff", {28'd0, sel}, 32'h8);
        wack = 1;
        #1;
        chk("t3_ack_ff", {31'd0, vlx_ack}, 1);
        nxt();
        wack = 0; vlx_req = 0; vlx_pair = 0;
        lsu_req = 1; lsu_we = 0; lsu_sel = 4'hF; lsu_adr = 32'h2000;
        chk("t3_hold_cyc", {31'd0, cyc}, 1);
        chk("t3_hold_stb", {31'd0, stb}, 0);
        chk("t3_hold_busy", {31'd0, vlx_busy}, 1);
        nxt();
        chk("t3_hold2_cyc", {31'd0, cyc}, 1);
        chk("t3_hold2_adr", adr, 32'h100);
        vlx_req = 1; vlx_adr = 32'h101; vlx_dat = 8'h00;
        nxt();
        chk("t3_00_cyc", {31'd0, cyc}, 1);
        chk("t3_00_stb", {31'd0, stb}, 1);
        chk("t3_00_adr", adr, 32'h101);
        chk("t3_00_sel", {28'd0, sel}, 32'h4);
        chk("t3_00_dat", wdat, 0);
        wack = 1;
        #1;
        chk("t3_ack_00", {31'd0, vlx_ack}, 1);
        chk("t3_lsu_wait", {31'd0, lsu_ack}, 0);
        nxt();
        wack = 0; vlx_req = 0;
        chk("t3_gap_cyc", {31'd0, cyc}, 0);
        nxt();
        chk("t3_lsu_adr", adr, 32'h2000);
        chk("t3_lsu_we", {31'd0, we}, 0);
        chk("t3_lsu_sel", {28'd0, sel}, 32'hF);
        chk("t3_lsu_busy", {31'd0, vlx_busy}, 0);
        wack = 1; rdat = 32'hDEADBEEF;
        #1;
        chk("t3_lsu_ack", {31'd0, lsu_ack}, 1);
        chk("t3_lsu_rdat", lsu_rdat, 32'hDEADBEEF);
        nxt();
        wack = 0; lsu_req = 0; rdat = 0;
        chk("t3_end_cyc", {31'd0, cyc}, 0);

        // Simultaneous requests, both held for four transfers
        lsu_req = 1; lsu_we = 1; lsu_adr = 32'h3000; lsu_dat = 32'h11223344;
        vlx_req = 1; vlx_adr = 32'h4003; vlx_dat = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("t4_busy", {31'd0, vlx_busy}, {31'd0, t4_vlx[i]});
            chk("t4_adr", adr, t4_vlx[i] ? 32'h4003 : 32'h3000);
            wack = 1;
            #1;
            chk("t4_vack", {31'd0, vlx_ack}, {31'd0, t4_vlx[i]});
            chk("t4_lack", {31'd0, lsu_ack}, {31'd0, ~t4_vlx[i]});
            nxt();
            wack = 0;
        end
        lsu_req = 0;
        nxt();
        chk("t4_last_busy", {31'd0, vlx_busy}, 1);
        chk("t4_last_sel", {28'd0, sel}, 32'h1);
        chk("t4_last_dat", wdat, 32'h5A5A5A5A);
        wack = 1;
        #1;
        chk("t4_last_ack", {31'd0, vlx_ack}, 1);
        nxt();
        wack = 0; vlx_req = 0;

        // Slave never responds: watchdog fires
        lsu_req = 1; lsu_we = 0; lsu_adr = 32'h5000;
        for (int i = 1; i <= 16; i++) begin
            nxt();
            chk("t5_wait_err", {31'd0, lsu_err}, 0);
            chk("t5_wait_stb", {31'd0, stb}, 1);
        end
        nxt();
        chk("t5_err", {31'd0, lsu_err}, 1);
        chk("t5_noack", {31'd0, lsu_ack}, 0);
        lsu_req = 0;
        vlx_req = 1; vlx_adr = 32'h6002; vlx_dat = 8'h77; vlx_pair = 0;
        #1;
        nxt();
        chk("t5_cyc_drop", {31'd0, cyc}, 0);
        chk("t5_err_gone", {31'd0, lsu_err}, 0);
        nxt();
        chk("t5_next_busy", {31'd0, vlx_busy}, 1);
        chk("t5_next_sel", {28'd0, sel}, 32'h2);
        wack = 1;
        #1;
        chk("t5_next_ack", {31'd0, vlx_ack}, 1);
        nxt();
        wack = 0; vlx_req = 0;

        // err and ack together during a pair: error wins, no hold
        vlx_req = 1; vlx_adr = 32'h7000; vlx_dat = 8'hFF; vlx_pair = 1;
        nxt();
        wack = 1; werr = 1;
        #1;
        chk("t6_err", {31'd0, vlx_err}, 1);
        chk("t6_noack", {31'd0, vlx_ack}, 0);
        chk("t6_lsu_err", {31'd0, lsu_err}, 0);
        nxt();
        wack = 0; werr = 0; vlx_req = 0; vlx_pair = 0;
        chk("t6_cyc", {31'd0, cyc}, 0);
        chk("t6_busy", {31'd0, vlx_busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
